counter60_stage: RTL and testbench
==================================

COUNTER60_STAGE -- requirements
Module: counter60_stage

Interface
REQ-001 SHALL have parameter: TENS_MAX, 5, highest tens digit; the count range is 00..TENS_MAX9, giving mod-60 by default.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port: rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: cin  input  1  count enable; a one-cycle carry pulse from the upstream decade counter's cout.
REQ-005 SHALL have port: clr  input  1  synchronous clear.
REQ-006 SHALL have port: load  input  1  synchronous preset strobe.
REQ-007 SHALL have port: load_tens  input  3  preset tens digit.
REQ-008 SHALL have port: load_ones  input  4  preset ones digit.
REQ-009 SHALL have port: ones  output  4  BCD ones digit, 0..9.
REQ-010 SHALL have port: tens  output  3  BCD tens digit, 0..TENS_MAX.
REQ-011 SHALL have port: cout  output  1  registered wrap pulse to the next stage.
REQ-012 SHALL have port: err  output  1  registered invalid-load pulse.
REQ-013 SHALL have port: seg_ones  output  7  seven-segment code for ones (gfedcba, active-high).
REQ-014 SHALL have port: seg_tens  output  7  seven-segment code for tens.

Function
REQ-015 SHALL give clr, load and cin the priority order clr > load > cin when sampled on the same edge.
REQ-016 SHALL, on clr, set tens/ones to 00 on that edge, with cout=0 and err=0.
REQ-017 SHALL, on a valid load (load_ones<=9 and load_tens<=TENS_MAX), present the loaded value on the next edge, with cout=0 regardless of the value loaded.
REQ-018 SHALL ignore an invalid load, hold the count, and set err=1 for exactly one cycle; any cin on that edge SHALL also be dropped.
REQ-019 SHALL, on cin with ones<9, increment ones by 1 and hold tens.
REQ-020 SHALL, on cin with ones=9 and tens<TENS_MAX, set ones=0 and increment tens by 1.
REQ-021 SHALL, on cin at TENS_MAX9, wrap to 00 and assert cout on the same edge, for exactly one cycle.
REQ-022 SHALL hold the count when cin is low; cout and err SHALL be 0 in every cycle that does not meet REQ-018/REQ-021.
REQ-023 SHALL count each cycle of a cin held high for N cycles once (no edge detect).
REQ-024 SHALL, for cin/clr together at TENS_MAX9, produce 00 with cout=0.
REQ-025 SHALL give the count zero latency from the sampling edge; cout is coincident with the 00 value.

Reset
REQ-026 SHALL, on rstn=0 and independently of clk, force ones=0, tens=0, cout=0, err=0, seg_ones=seg_tens=code for "0" (7'h3F), or 7'h00 without the macro.
REQ-027 SHALL resume counting on the first rising clk edge after rstn deasserts; a reset mid-count SHALL lose the count and a pending cout.

Configuration
REQ-028 SHALL, when SEG7_DECODE_EN is defined, drive seg_ones/seg_tens as registered decodes of the next-state digits, aligned with ones/tens (no extra cycle).
REQ-029 SHALL, when SEG7_DECODE_EN is undefined, keep the seg_* ports present, tie them to 7'h00, and infer no decode logic.

Structure
REQ-030 SHALL place in the shared package/include: the segment code table for 0..9, the blank code 7'h00, and the BCD digit maximum 4'd9.
REQ-031 SHALL contain one sub-module, bcd_digit (parameterised max, inputs inc/clr/load/value, outputs digit and wrap), instantiated twice: the ones cell with max 9 and the tens cell with max TENS_MAX, where the tens cell's inc = cin & ones_wrap.

Verification
REQ-032 SHALL cover: reset held, then released at 11 ns with a 20 ns clk period -> ones=0, tens=0, cout=0, seg_ones=7'h3F.
REQ-033 SHALL cover: 60 cin pulses, one every 10th cycle (from a counter10 upstream) -> 01..59 then 00; cout high exactly once, in the cycle showing 00.
REQ-034 SHALL cover: load 5/8, then cin for 3 cycles -> 58, 59, 00 (cout=1), 01.
REQ-035 SHALL cover: load_ones=12 with load_tens=1 -> err=1 for one cycle, count unchanged; load_tens=6 (TENS_MAX=5) -> same.
REQ-036 SHALL cover: at 59, clr+load+cin on the same edge -> 00, cout=0, err=0; rstn pulsed low mid-count at 37 -> 00 immediately, without waiting for clk.
REQ-037 SHALL cover: with the macro undefined -> seg_ones=seg_tens=7'h00 throughout the REQ-033 run.

Source files
------------

// File: rtl/counter60_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : counter60_stage_pkg
// Purpose  : Shared constants for the BCD minute/second counter stage:
//            digit maximum, blank segment code and the 7-segment table.
// Revision : 1.0 - initial release
// ============================================================================
package counter60_stage_pkg;

    localparam logic [3:0] BCD_MAX   = 4'd9;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // gfedcba, active-high; entries 10..15 are blank so any 4-bit index is safe
    localparam logic [15:0][6:0] SEG_TABLE = {
        SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK,
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] seg7_decode(input logic [3:0] digit);
        return SEG_TABLE[digit];
    endfunction

endpackage
`default_nettype wire

// File: rtl/counter60_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : counter60_stage_if
// Purpose  : Control and result bundle of the counter60_stage block.
// Revision : 1.0 - initial release
// ============================================================================
interface counter60_stage_if;

    logic       cin;
    logic       clr;
    logic       load;
    logic [2:0] load_tens;
    logic [3:0] load_ones;
    logic [3:0] ones;
    logic [2:0] tens;
    logic       cout;
    logic       err;
    logic [6:0] seg_ones;
    logic [6:0] seg_tens;

    modport master (
        output cin, clr, load, load_tens, load_ones,
        input  ones, tens, cout, err, seg_ones, seg_tens
    );

    modport slave (
        input  cin, clr, load, load_tens, load_ones,
        output ones, tens, cout, err, seg_ones, seg_tens
    );

endinterface
`default_nettype wire

// File: rtl/counter60_stage_bcd_digit.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit
// Purpose  : One registered decimal digit 0..MAX with clear > load > inc
//            priority; wrap flags that the digit currently sits at MAX.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_digit
    import counter60_stage_pkg::*;
#(
    parameter int MAX   = int'(BCD_MAX),
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             inc,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] digit,
    output logic [WIDTH-1:0] digit_next,
    output logic             wrap
);

    assign wrap = (digit == WIDTH'(MAX));

    always_comb begin
        digit_next = digit;
        if (clr) begin
            digit_next = '0;
        end else if (load) begin
            digit_next = value;
        end else if (inc) begin
            digit_next = wrap ? '0 : digit + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            digit <= '0;
        end else begin
            digit <= digit_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/counter60_stage.sv
`default_nettype none
// ============================================================================
// Module   : counter60_stage
// Purpose  : Cascadable BCD 00..TENS_MAX9 counter stage with preset, clear,
//            registered wrap/err pulses. Optional 7-segment outputs are
//            enabled by defining SEG7_DECODE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module counter60_stage
    import counter60_stage_pkg::*;
#(
    parameter int TENS_MAX = 5
) (
    input  logic                    clk,
    input  logic                    rstn,
    counter60_stage_if.slave        bus
);

    logic       load_ok;
    logic       ones_load;
    logic       ones_inc;
    logic       tens_inc;
    logic       ones_wrap;
    logic       tens_wrap;
    logic       cout_next;
    logic       err_next;
    logic [3:0] ones_next;
    logic [2:0] tens_next;

    assign load_ok   = (bus.load_ones <= BCD_MAX) && (bus.load_tens <= 3'(TENS_MAX));
    assign ones_load = bus.load & load_ok;
    // any load strobe, valid or not, swallows a coincident carry-in
    assign ones_inc  = bus.cin & ~bus.load & ~bus.clr;
    assign tens_inc  = ones_inc & ones_wrap;
    assign cout_next = tens_inc & tens_wrap;
    assign err_next  = bus.load & ~load_ok & ~bus.clr;

    bcd_digit #(
        .MAX   (int'(BCD_MAX)),
        .WIDTH (4)
    ) u_ones (
        .clk        (clk),
        .rstn       (rstn),
        .inc        (ones_inc),
        .clr        (bus.clr),
        .load       (ones_load),
        .value      (bus.load_ones),
        .digit      (bus.ones),
        .digit_next (ones_next),
        .wrap       (ones_wrap)
    );

    bcd_digit #(
        .MAX   (TENS_MAX),
        .WIDTH (3)
    ) u_tens (
        .clk        (clk),
        .rstn       (rstn),
        .inc        (tens_inc),
        .clr        (bus.clr),
        .load       (ones_load),
        .value      (bus.load_tens),
        .digit      (bus.tens),
        .digit_next (tens_next),
        .wrap       (tens_wrap)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.cout <= 1'b0;
            bus.err  <= 1'b0;
        end else begin
            bus.cout <= cout_next;
            bus.err  <= err_next;
        end
    end

`ifdef SEG7_DECODE_EN
    // decoding next-state digits keeps the segments aligned with ones/tens
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.seg_ones <= SEG_TABLE[0];
            bus.seg_tens <= SEG_TABLE[0];
        end else begin
            bus.seg_ones <= seg7_decode(ones_next);
            bus.seg_tens <= seg7_decode({1'b0, tens_next});
        end
    end
`else
    logic unused_next;
    assign unused_next  = ^{ones_next, tens_next};
    assign bus.seg_ones = SEG_BLANK;
    assign bus.seg_tens = SEG_BLANK;
`endif

endmodule
`default_nettype wire

// File: tb/tb_counter60_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter60_stage
// Purpose  : Self-checking bench for counter60_stage against an arithmetic
//            model of the count value (0..TENS_MAX*10+9).
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter60_stage;

    localparam int TMAX  = 5;
    localparam int LIMIT = TMAX * 10 + 9;

    logic clk;
    logic rstn;
    counter60_stage_if bus();

    counter60_stage #(.TENS_MAX(TMAX)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int m_count;
    bit m_cout;
    bit m_err;
    int cout_seen;

    function automatic logic [6:0] exp_seg(input int d);
`ifdef SEG7_DECODE_EN
        case (d)
            0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F;
            4: return 7'h66; 5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07;
            8: return 7'h7F; 9: return 7'h6F; default: return 7'h00;
        endcase
`else
        return (d >= 0) ? 7'h00 : 7'h00;
`endif
    endfunction

    task automatic compare(input string tag);
        int eo, et;
        eo = m_count % 10;
        et = m_count / 10;
        n_vec++;
        if (int'(bus.ones) != eo || int'(bus.tens) != et || bus.cout != m_cout ||
            bus.err != m_err || bus.seg_ones != exp_seg(eo) || bus.seg_tens != exp_seg(et)) begin
            n_bad++;
            $display("FAIL %s t=%0t: got %0d%0d cout=%0b err=%0b seg=%h/%h, expected %0d%0d cout=%0b err=%0b seg=%h/%h",
                     tag, $time, bus.tens, bus.ones, bus.cout, bus.err, bus.seg_tens, bus.seg_ones,
                     et, eo, m_cout, m_err, exp_seg(et), exp_seg(eo));
        end
    endtask

    task automatic check_lit(input string tag, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s t=%0t: got %0d, expected %0d", tag, $time, act, exp);
        end
    endtask

    // one clock: drive inputs, apply the counting rules at the edge, compare at negedge
    task automatic cycle(input bit c, input bit cl, input bit ld, input int lt, input int lo);
        bus.cin = c; bus.clr = cl; bus.load = ld;
        bus.load_tens = 3'(lt); bus.load_ones = 4'(lo);
        @(posedge clk);
        #1;
        m_cout = 0;
        m_err  = 0;
        if (cl) m_count = 0;
        else if (ld) begin
            if (lo <= 9 && lt <= TMAX) m_count = lt * 10 + lo;
            else m_err = 1;
        end else if (c) begin
            if (m_count == LIMIT) begin m_count = 0; m_cout = 1; end
            else m_count = m_count + 1;
        end
        @(negedge clk);
        compare("cycle");
        if (bus.cout) cout_seen++;
    endtask

    int start;

    initial begin
        rstn = 1'b0;
        bus.cin = 0; bus.clr = 0; bus.load = 0; bus.load_tens = 0; bus.load_ones = 0;
        m_count = 0; m_cout = 0; m_err = 0; cout_seen = 0;
        #5;
        compare("reset_held");
        #6 rstn = 1'b1;
        @(negedge clk);
        compare("reset_release");
        check_lit("reset_ones", int'(bus.ones), 0);
        check_lit("reset_tens", int'(bus.tens), 0);
`ifdef SEG7_DECODE_EN
        check_lit("reset_seg", int'(bus.seg_ones), 'h3F);
`else
        check_lit("reset_seg", int'(bus.seg_ones), 0);
`endif

        // sixty carries from an upstream decade counter
        cout_seen = 0;
        for (int i = 0; i < 600; i++) cycle(i % 10 == 9, 0, 0, 0, 0);
        check_lit("mod60_cout_count", cout_seen, 1);
        check_lit("mod60_final", int'(bus.tens) * 10 + int'(bus.ones), 0);

        // preset then count across the wrap
        cycle(0, 0, 1, 5, 8);
        check_lit("load58", int'(bus.tens) * 10 + int'(bus.ones), 58);
        cycle(1, 0, 0, 0, 0);
        check_lit("inc59", int'(bus.tens) * 10 + int'(bus.ones), 59);
        cycle(1, 0, 0, 0, 0);
        check_lit("wrap00", int'(bus.tens) * 10 + int'(bus.ones), 0);
        check_lit("wrap_cout", int'(bus.cout), 1);
        cycle(1, 0, 0, 0, 0);
        check_lit("inc01", int'(bus.tens) * 10 + int'(bus.ones), 1);
        check_lit("cout_one_cycle", int'(bus.cout), 0);

        // invalid presets, with a coincident carry that must be dropped
        cycle(1, 0, 1, 1, 12);
        check_lit("bad_ones_err", int'(bus.err), 1);
        check_lit("bad_ones_hold", int'(bus.tens) * 10 + int'(bus.ones), 1);
        cycle(0, 0, 0, 0, 0);
        check_lit("err_one_cycle", int'(bus.err), 0);
        cycle(1, 0, 1, 6, 3);
        check_lit("bad_tens_err", int'(bus.err), 1);
        check_lit("bad_tens_hold", int'(bus.tens) * 10 + int'(bus.ones), 1);

        // clear beats load and carry at the top count
        cycle(0, 0, 1, 5, 9);
        cycle(1, 1, 1, 5, 9);
        check_lit("clr_prio", int'(bus.tens) * 10 + int'(bus.ones), 0);
        check_lit("clr_prio_cout", int'(bus.cout), 0);
        check_lit("clr_prio_err", int'(bus.err), 0);

        // asynchronous reset in the middle of a count
        cycle(0, 0, 1, 3, 7);
        #3 rstn = 1'b0;
        #1;
        m_count = 0; m_cout = 0; m_err = 0;
        check_lit("async_rst", int'(bus.tens) * 10 + int'(bus.ones), 0);
        compare("async_rst");
        #2 rstn = 1'b1;

        // carry held high counts every cycle
        start = m_count;
        for (int i = 0; i < 70; i++) cycle(1, 0, 0, 0, 0);
        check_lit("held_cin", int'(bus.tens) * 10 + int'(bus.ones), (start + 70) % 60);

        // randomized mix
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            cycle(r < 60, r >= 95, (r >= 85 && r < 95) || (r < 5),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
